// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and decode helpers for the MIPS load/store unit.
// Opcode encoding is fixed; values 10-15 are unknown and complete as erroring loads.
package mips_cpu_lsu_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LBU = 4'd1,
    LH  = 4'd2,
    LHU = 4'd3,
    LW  = 4'd4,
    LWL = 4'd5,
    LWR = 4'd6,
    SB  = 4'd7,
    SH  = 4'd8,
    SW  = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic is_known_op(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  // Byte and half stores need the old word first, so they go through READ.
  function automatic logic is_rmw_store(input logic [3:0] op);
    return (op == SB) || (op == SH);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      LH, LHU, SH: mis = off[0];
      LW, SW:      mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Combinational lane logic: load extraction/sign extension, LWL/LWR merge with rt,
// and the read-modify-write merge for byte/half stores. Little-endian lanes.
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] mem_word_i,
  input  logic [31:0] rt_old_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [4:0]  lwl_sh;
  logic [4:0]  lwr_sh;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // 3-k equals ~k on two bits, so both shifts are just the offset scaled by 8.
  assign lwl_sh = {~byte_off_i, 3'b000};
  assign lwr_sh = {byte_off_i, 3'b000};

  always_comb begin
    sel_byte = mem_word_i[7:0];
    case (byte_off_i)
      2'd0:    sel_byte = mem_word_i[7:0];
      2'd1:    sel_byte = mem_word_i[15:8];
      2'd2:    sel_byte = mem_word_i[23:16];
      default: sel_byte = mem_word_i[31:24];
    endcase
    sel_half = byte_off_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
  end

  always_comb begin
    load_data_o = mem_word_i;
    case (op_i)
      LB:      load_data_o = {{24{sel_byte[7]}}, sel_byte};
      LBU:     load_data_o = {24'h000000, sel_byte};
      LH:      load_data_o = {{16{sel_half[15]}}, sel_half};
      LHU:     load_data_o = {16'h0000, sel_half};
      LWL:     load_data_o = (mem_word_i << lwl_sh) | (rt_old_i & ~(32'hFFFF_FFFF << lwl_sh));
      LWR:     load_data_o = (mem_word_i >> lwr_sh) | (rt_old_i & ~(32'hFFFF_FFFF >> lwr_sh));
      default: load_data_o = mem_word_i;
    endcase
  end

  always_comb begin
    store_word_o = mem_word_i;
    case (op_i)
      SB:      store_word_o = (mem_word_i & ~(32'h0000_00FF << lwr_sh))
                            | ({24'h000000, wdata_i[7:0]} << lwr_sh);
      SH:      store_word_o = byte_off_i[1] ? {wdata_i, mem_word_i[15:0]}
                                            : {mem_word_i[31:16], wdata_i};
      default: store_word_o = mem_word_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Load/store sequencer for a word-wide memory that reads combinationally and writes
// on posedge. Sub-word stores become read-modify-write; loads are extracted on READ exit.
module mips_cpu_load_store_unit
  import mips_cpu_lsu_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rt_old,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  output lsu_state_t  dbg_state_o
);

  // Handshake: a request transfers on a posedge where req && ready; ready is high only
  // in IDLE, and exactly one done pulse follows every accepted request.

  lsu_state_t  state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] store_word;

  mips_cpu_lsu_align u_align (
    .op_i        (op_q),
    .byte_off_i  (addr_q[1:0]),
    .mem_word_i  (data_readdata),
    .rt_old_i    (rt_old_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .store_word_o(store_word)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rt_old_d   = rt_old_q;
    merge_d    = merge_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ready      = 1'b0;
    done       = 1'b0;
    data_read  = 1'b0;
    data_write = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (req) begin
          op_d     = op;
          addr_d   = addr;
          wdata_d  = wdata[15:0];
          rt_old_d = rt_old;
          err_d    = 1'b0;
          if (CHECK_ALIGN && is_misaligned(op, addr[1:0])) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = ST_RESP;
          end else if (op == SW) begin
            merge_d = wdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_read = 1'b1;
        if (is_rmw_store(op_q)) begin
          merge_d = store_word;
          state_d = ST_WRITE;
        end else begin
          rdata_d = load_data;
          err_d   = !is_known_op(op_q);
          state_d = ST_RESP;
        end
      end
      ST_WRITE: begin
        data_write = 1'b1;
        state_d    = ST_RESP;
      end
      default: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 16'h0;
      rt_old_q <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rt_old_q <= rt_old_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rdata          = rdata_q;
  assign err            = err_q;
  assign data_address   = {addr_q[31:2], 2'b00};
  assign data_writedata = merge_q;
  assign dbg_state_o    = state_q;

endmodule
